// File: rtl/sspis_pkg.sv
// Shared command codes, FSM states and status-byte layout for the SPI register bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sspis_pkg;

  localparam logic [7:0] CMD_WR = 8'h02;
  localparam logic [7:0] CMD_RD = 8'h03;
  localparam logic [7:0] CMD_ST = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_RDUMMY,
    ST_RDATA,
    ST_STATUS,
    ST_IGNORE
  } state_t;

  localparam int STAT_RD_TMO   = 0;
  localparam int STAT_WR_OVR   = 1;
  localparam int STAT_BUS_BUSY = 2;

  function automatic logic [7:0] status_byte(input logic busy, input logic ovr, input logic tmo);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_BUS_BUSY] = busy;
    s[STAT_WR_OVR]   = ovr;
    s[STAT_RD_TMO]   = tmo;
    return s;
  endfunction

endpackage

// File: rtl/sspis_sync.sv
// Two-flop synchronizer for sck/ssn/si with sck and ssn edge pulses.
// Latency: 2 app_clk to synced level, edge pulse acted on 3 app_clk after the pin edge.
// Backpressure: none; pins are sampled every app_clk.
module sspis_sync (
  input  logic app_clk,
  input  logic arst_n,
  input  logic sck,
  input  logic ssn,
  input  logic si,
  output logic si_s,
  output logic ssn_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic ssn_rise,
  output logic ssn_fall
);

  logic [2:0] sck_q;
  logic [2:0] ssn_q;
  logic [1:0] si_q;

  // ssn resets high so a deselected bus never produces a spurious frame start
  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) begin
      sck_q <= 3'b000;
      ssn_q <= 3'b111;
      si_q  <= 2'b00;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      ssn_q <= {ssn_q[1:0], ssn};
      si_q  <= {si_q[0], si};
    end
  end

  assign si_s     = si_q[1];
  assign ssn_s    = ssn_q[1];
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ssn_rise = ssn_q[1] & ~ssn_q[2];
  assign ssn_fall = ~ssn_q[1] & ssn_q[2];

endmodule

// File: rtl/sspis_reg_bridge.sv
// SPI mode-0 target turning WRITE/READ/STATUS frames into register-bus transactions.
// Latency: 3 app_clk pin-to-action; write request 1 cycle after the last data bit is seen.
// Backpressure: a write arriving while the bus is busy is dropped (wr_ovr); late read data is dropped (rd_tmo).
module sspis_reg_bridge
  import sspis_pkg::*;
(
  input  logic        app_clk,
  input  logic        arst_n,
  input  logic        sck,
  input  logic        ssn,
  input  logic        si,
  output logic        so,
  output logic        so_en,
  output logic        reg_cs,
  output logic        reg_wr,
  output logic [31:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack
);

  logic        si_s, ssn_s, sck_rise, sck_fall, ssn_rise, ssn_fall;
  state_t      state_q, state_d;
  logic [5:0]  cnt;
  logic [31:0] rx_sr, rx_next, tx_sr, addr, rbuf, tx_word;
  logic        cmd_rd, so_q, buf_vld, rd_want, rd_keep, rd_tmo, wr_ovr;
  logic        cmd_done, addr_done, word_done, st_done, tx_load, tx_state;
  logic        rd_ack, rd_accept, buf_avail;

  sspis_sync u_sync (
    .app_clk  (app_clk),
    .arst_n   (arst_n),
    .sck      (sck),
    .ssn      (ssn),
    .si       (si),
    .si_s     (si_s),
    .ssn_s    (ssn_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ssn_rise (ssn_rise),
    .ssn_fall (ssn_fall)
  );

  assign rx_next   = {rx_sr[30:0], si_s};
  assign rd_ack    = reg_cs & reg_ack & ~reg_wr;
  assign rd_accept = rd_ack & rd_keep & ~ssn_rise;
  // an ack landing on the word-load cycle feeds the shifter directly
  assign buf_avail = buf_vld | (rd_ack & rd_keep);
  assign tx_word   = buf_vld ? rbuf : reg_rdata;
  assign tx_state  = (state_q == ST_RDUMMY) || (state_q == ST_RDATA) || (state_q == ST_STATUS);
  assign so_en     = tx_state & ~ssn_s;
  assign so        = so_q & so_en;
  assign reg_be    = 4'hF;

  always_comb begin
    state_d   = state_q;
    cmd_done  = 1'b0;
    addr_done = 1'b0;
    word_done = 1'b0;
    st_done   = 1'b0;
    tx_load   = 1'b0;
    if (ssn_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (ssn_fall) state_d = ST_CMD;
        ST_CMD: if (sck_rise && cnt == 6'd7) begin
          cmd_done = 1'b1;
          if (rx_next[7:0] == CMD_WR || rx_next[7:0] == CMD_RD) state_d = ST_ADDR;
          else if (rx_next[7:0] == CMD_ST)                      state_d = ST_STATUS;
          else                                                  state_d = ST_IGNORE;
        end
        ST_ADDR: if (sck_rise && cnt == 6'd31) begin
          addr_done = 1'b1;
          state_d   = cmd_rd ? ST_RDUMMY : ST_WDATA;
        end
        ST_WDATA:  word_done = sck_rise && cnt == 6'd31;
        ST_RDUMMY: if (sck_rise && cnt == 6'd7) state_d = ST_RDATA;
        ST_RDATA:  tx_load = sck_fall && cnt == 6'd0;
        ST_STATUS: if (sck_rise && cnt == 6'd7) begin
          st_done = 1'b1;
          state_d = ST_IGNORE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt       <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      so_q      <= 1'b0;
      cmd_rd    <= 1'b0;
      addr      <= '0;
      rbuf      <= '0;
      buf_vld   <= 1'b0;
      rd_want   <= 1'b0;
      rd_keep   <= 1'b0;
      rd_tmo    <= 1'b0;
      wr_ovr    <= 1'b0;
      reg_cs    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      if (state_d != state_q) cnt <= '0;
      else if (sck_rise)
        cnt <= (cnt == 6'd31 && (state_q == ST_WDATA || state_q == ST_RDATA)) ? 6'd0 : cnt + 6'd1;
      if (sck_rise) rx_sr <= rx_next;

      if (reg_cs && reg_ack) begin
        reg_cs  <= 1'b0;
        rd_keep <= 1'b0;
      end else if (!reg_cs && rd_want) begin
        reg_cs   <= 1'b1;
        reg_wr   <= 1'b0;
        reg_addr <= addr;
        rd_want  <= 1'b0;
        rd_keep  <= 1'b1;
      end

      if (rd_accept) begin
        addr <= addr + 32'd4;
        if (!tx_load) begin
          rbuf    <= reg_rdata;
          buf_vld <= 1'b1;
        end
      end

      if (cmd_done) begin
        cmd_rd <= (rx_next[7:0] == CMD_RD);
        tx_sr  <= {status_byte(reg_cs, wr_ovr, rd_tmo), 24'h0};
        so_q   <= 1'b0;
      end

      if (addr_done) begin
        addr    <= rx_next;
        rd_want <= cmd_rd;
        tx_sr   <= '0;
        so_q    <= 1'b0;
      end

      if (tx_load) begin
        if (buf_avail) begin
          tx_sr   <= {tx_word[30:0], 1'b0};
          so_q    <= tx_word[31];
          buf_vld <= 1'b0;
          rd_want <= 1'b1;
        end else begin
          tx_sr   <= '0;
          so_q    <= 1'b0;
          rd_tmo  <= 1'b1;
          rd_keep <= 1'b0;
          rd_want <= 1'b0;
        end
      end else if (sck_fall && tx_state) begin
        so_q  <= tx_sr[31];
        tx_sr <= {tx_sr[30:0], 1'b0};
      end

      // a still-pending previous write means this word has nowhere to go
      if (word_done) begin
        if (reg_cs) begin
          wr_ovr <= 1'b1;
        end else begin
          reg_cs    <= 1'b1;
          reg_wr    <= 1'b1;
          reg_addr  <= addr;
          reg_wdata <= rx_next;
          addr      <= addr + 32'd4;
        end
      end

      if (st_done) begin
        rd_tmo <= 1'b0;
        wr_ovr <= 1'b0;
      end

      if (ssn_rise) begin
        rd_want <= 1'b0;
        rd_keep <= 1'b0;
        buf_vld <= 1'b0;
      end
    end
  end

endmodule
